// File: rtl/vga_scan_engine.sv
// VGA scan/timing engine with framebuffer fetch.
// Generates H/V sync and blanking from free-running counters, walks the framebuffer address
// incrementally (pixel and line replication, no multiplier) and registers the memory colour.
// Sync, visible and frame-start flags are delayed through matching chains so that every pin
// reflects the same counter cycle.
module vga_scan_engine #(
  parameter int unsigned H_BACK       = 24,
  parameter int unsigned H_VISIBLE    = 320,
  parameter int unsigned H_FRONT      = 8,
  parameter int unsigned H_SYNC       = 48,
  parameter int unsigned V_BACK       = 35,
  parameter int unsigned V_VISIBLE    = 400,
  parameter int unsigned V_FRONT      = 12,
  parameter int unsigned V_SYNC       = 2,
  parameter bit          H_SYNC_POL   = 1'b0,
  parameter bit          V_SYNC_POL   = 1'b1,
  parameter int unsigned H_SCALE      = 1,
  parameter int unsigned V_SCALE      = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned COLOR_W      = 12
) (
  input  logic                   i_vga_clk,
  input  logic                   i_reset,
  input  logic                   i_display_en,
  output logic [ADDR_W-1:0]      o_read_addr,
  input  logic [COLOR_W-1:0]     i_read_data,
  output logic [COLOR_W/3-1:0]   o_vga_r,
  output logic [COLOR_W/3-1:0]   o_vga_g,
  output logic [COLOR_W/3-1:0]   o_vga_b,
  output logic                   o_vga_hs,
  output logic                   o_vga_vs,
  output logic                   o_frame_start,
  output logic                   o_vblank
);

  localparam int unsigned H_TOTAL = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned V_TOTAL = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HSW     = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
  localparam int unsigned VSW     = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
  localparam int unsigned PIPE    = READ_LATENCY + 2;
  localparam int unsigned CW      = COLOR_W / 3;

  localparam logic [HW-1:0]     H_VIS_BEG    = HW'(H_BACK);
  localparam logic [HW-1:0]     H_VIS_LAST   = HW'(H_BACK + H_VISIBLE - 1);
  localparam logic [HW-1:0]     H_SYNC_BEG   = HW'(H_TOTAL - H_SYNC);
  localparam logic [HW-1:0]     H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]     V_VIS_BEG    = VW'(V_BACK);
  localparam logic [VW-1:0]     V_VIS_LAST   = VW'(V_BACK + V_VISIBLE - 1);
  localparam logic [VW-1:0]     V_SYNC_BEG   = VW'(V_TOTAL - V_SYNC);
  localparam logic [VW-1:0]     V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HSW-1:0]    H_SCALE_LAST = HSW'(H_SCALE - 1);
  localparam logic [VSW-1:0]    V_SCALE_LAST = VSW'(V_SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(H_VISIBLE / H_SCALE);

  // Counter stage
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_h_vis;
  logic              w_v_vis;
  logic              w_vis;
  logic              w_hs_act;
  logic              w_vs_act;
  logic              w_frame_start;

  // Address generation
  logic [ADDR_W-1:0] r_row_base;
  logic [VSW-1:0]    r_vcnt;
  logic [ADDR_W-1:0] r_pix;
  logic [HSW-1:0]    r_hcnt;
  logic [ADDR_W-1:0] r_read_addr;
  logic              w_line_first;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [HSW-1:0]    w_cur_hcnt;

  // Alignment chains and colour register
  logic [PIPE-1:0]   r_hs_pipe;
  logic [PIPE-1:0]   r_vs_pipe;
  logic [PIPE-1:0]   r_fs_pipe;
  logic [PIPE-2:0]   r_vis_pipe;
  logic [PIPE-2:0]   r_en_pipe;
  logic [COLOR_W-1:0] r_color;

  // Decode window, sync and frame-start flags from the current counter values
  always_comb begin
    w_h_last      = (r_h == H_LAST);
    w_v_last      = (r_v == V_LAST);
    w_h_vis       = (r_h >= H_VIS_BEG) && (r_h <= H_VIS_LAST);
    w_v_vis       = (r_v >= V_VIS_BEG) && (r_v <= V_VIS_LAST);
    w_vis         = w_h_vis && w_v_vis;
    w_hs_act      = (r_h >= H_SYNC_BEG);
    w_vs_act      = (r_v >= V_SYNC_BEG);
    w_frame_start = w_vis && (r_h == H_VIS_BEG) && (r_v == V_VIS_BEG);
    w_line_first  = (r_h == H_VIS_BEG);
    // The first visible cycle of a line restarts from the row base regardless of leftovers
    w_cur_addr    = w_line_first ? r_row_base : r_pix;
    w_cur_hcnt    = w_line_first ? '0 : r_hcnt;
  end

  // Horizontal and vertical scan counters
  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Pixel address walk within a line, replicating each address H_SCALE cycles
  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_pix       <= '0;
      r_hcnt      <= '0;
      r_read_addr <= '0;
    end else if (w_vis) begin
      r_read_addr <= w_cur_addr;
      if (w_cur_hcnt == H_SCALE_LAST) begin
        r_pix  <= w_cur_addr + ADDR_W'(1);
        r_hcnt <= '0;
      end else begin
        r_pix  <= w_cur_addr;
        r_hcnt <= w_cur_hcnt + HSW'(1);
      end
    end
  end

  // Row base: cleared for each new frame, advanced after every V_SCALE-th visible line
  always_ff @(posedge i_vga_clk) begin
    if (i_reset || (w_h_last && w_v_last)) begin
      r_row_base <= '0;
      r_vcnt     <= '0;
    end else if (w_vis && (r_h == H_VIS_LAST)) begin
      if (r_vcnt == V_SCALE_LAST) begin
        r_row_base <= r_row_base + ROW_STEP;
        r_vcnt     <= '0;
      end else begin
        r_vcnt     <= r_vcnt + VSW'(1);
      end
    end
  end

  // Delay chains: sync/frame-start span the full pipe, visible/enable stop at the colour register
  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_hs_pipe  <= '0;
      r_vs_pipe  <= '0;
      r_fs_pipe  <= '0;
      r_vis_pipe <= '0;
      r_en_pipe  <= '0;
    end else begin
      r_hs_pipe  <= {r_hs_pipe[PIPE-2:0], w_hs_act};
      r_vs_pipe  <= {r_vs_pipe[PIPE-2:0], w_vs_act};
      r_fs_pipe  <= {r_fs_pipe[PIPE-2:0], w_frame_start};
      r_vis_pipe <= {r_vis_pipe[PIPE-3:0], w_vis};
      r_en_pipe  <= {r_en_pipe[PIPE-3:0], i_display_en};
    end
  end

  // Colour output register, blanked outside the window or when display is disabled
  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_color <= '0;
    end else if (r_vis_pipe[PIPE-2] && r_en_pipe[PIPE-2]) begin
      r_color <= i_read_data;
    end else begin
      r_color <= '0;
    end
  end

  // Simulation guard on counter range
  always_ff @(posedge i_vga_clk) begin
    if (!i_reset) begin
      assert (r_h <= H_LAST) else $error("vga_scan_engine: h counter out of range");
      assert (r_v <= V_LAST) else $error("vga_scan_engine: v counter out of range");
    end
  end

  assign o_read_addr   = r_read_addr;
  assign o_vga_r       = r_color[CW-1:0];
  assign o_vga_g       = r_color[2*CW-1:CW];
  assign o_vga_b       = r_color[3*CW-1:2*CW];
  assign o_vga_hs      = r_hs_pipe[PIPE-1] ? H_SYNC_POL : ~H_SYNC_POL;
  assign o_vga_vs      = r_vs_pipe[PIPE-1] ? V_SYNC_POL : ~V_SYNC_POL;
  assign o_frame_start = r_fs_pipe[PIPE-1];
  // vblank follows the counter directly rather than the pin-aligned chain
  assign o_vblank      = ~w_v_vis;

endmodule
